// File: rtl/uart_program_loader_if.sv
// Serial-in / instruction-memory-write bundle between the RX pin, the loader and the CPU.
interface uart_program_loader_if #(
   parameter int unsigned ADDR_W = 11,
   parameter int unsigned DATA_W = 16
);
   logic              uart_rx;
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              cpu_hold;
   logic              load_done;
   logic              frame_err;

   modport master (
      input  uart_rx,
      output wr_en, wr_addr, wr_data, cpu_hold, load_done, frame_err
   );

   modport slave (
      output uart_rx,
      input  wr_en, wr_addr, wr_data, cpu_hold, load_done, frame_err
   );
endinterface

// File: rtl/uart_program_loader.sv
// UART program loader: receives a framed image and writes 16-bit words into instruction RAM.
// Optional trailing checksum byte enabled by defining LOADER_CKSUM_EN.
module uart_program_loader #(
   parameter int unsigned CLKS_PER_BIT = 234,
   parameter int unsigned ADDR_W       = 11,
   parameter int unsigned DATA_W       = 16,
   parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
   input logic                    clk,
   input logic                    rst_n,
   uart_program_loader_if.master  bus
);
   localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int unsigned HALF  = CLKS_PER_BIT / 2;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;
   typedef enum logic [2:0] {
      IDLE, LEN_LO, LEN_HI, DATA_LO, DATA_HI,
`ifdef LOADER_CKSUM_EN
      CKSUM,
`endif
      DONE
   } ld_state_t;

`ifdef LOADER_CKSUM_EN
   localparam ld_state_t TAIL = CKSUM;
`else
   localparam ld_state_t TAIL = DONE;
`endif

   logic             rx_meta, rx_s, rx_prev;
   bit_state_t       bstate;
   logic [CNT_W-1:0] cnt;
   logic [2:0]       bit_idx;
   logic [7:0]       shreg;
   logic             byte_valid, byte_err;

   ld_state_t         state;
   logic [7:0]        len_lo, lo_byte;
   logic [15:0]       words_left;
   logic              wr_en, cpu_hold, load_done, frame_err;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;

   // Two-flop synchroniser plus delayed copy for start-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= bus.uart_rx;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Bit engine: mid-bit sampling, LSB first, one pulse per received byte or framing error
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bstate     <= B_IDLE;
         cnt        <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         byte_err   <= 1'b0;
         case (bstate)
            B_IDLE: begin
               cnt <= '0;
               if (rx_prev && !rx_s) bstate <= B_START;
            end
            B_START: begin
               if (cnt == CNT_W'(HALF - 1)) begin
                  cnt     <= '0;
                  bit_idx <= '0;
                  bstate  <= rx_s ? B_IDLE : B_DATA;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            B_DATA: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt     <= '0;
                  shreg   <= {rx_s, shreg[7:1]};
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) bstate <= B_STOP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            B_STOP: begin
               if (cnt == CNT_W'(CLKS_PER_BIT - 1)) begin
                  cnt    <= '0;
                  bstate <= B_IDLE;
                  if (rx_s) byte_valid <= 1'b1;
                  else      byte_err   <= 1'b1;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: bstate <= B_IDLE;
         endcase
      end
   end

`ifdef LOADER_CKSUM_EN
   logic [7:0] cksum;

   // Running sum of every byte after the sync byte
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cksum <= '0;
      end else if (state == IDLE) begin
         cksum <= '0;
      end else if (byte_valid && state inside {LEN_LO, LEN_HI, DATA_LO, DATA_HI}) begin
         cksum <= cksum + shreg;
      end
   end
`endif

   // Frame parser and instruction-memory write sequencing
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         len_lo     <= '0;
         lo_byte    <= '0;
         words_left <= '0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         cpu_hold   <= 1'b0;
         load_done  <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         wr_en     <= 1'b0;
         load_done <= 1'b0;
         if (wr_en) wr_addr <= wr_addr + ADDR_W'(1);

         if (byte_err && state != IDLE && state != DONE) begin
            frame_err <= 1'b1;
            cpu_hold  <= 1'b0;
            state     <= IDLE;
         end else begin
            case (state)
               IDLE: begin
                  if (byte_valid && shreg == SYNC_BYTE) begin
                     state     <= LEN_LO;
                     cpu_hold  <= 1'b1;
                     frame_err <= 1'b0;
                     wr_addr   <= '0;
                  end
               end
               LEN_LO: begin
                  if (byte_valid) begin
                     len_lo <= shreg;
                     state  <= LEN_HI;
                  end
               end
               LEN_HI: begin
                  if (byte_valid) begin
                     words_left <= {shreg, len_lo};
                     state      <= ({shreg, len_lo} == 16'd0) ? TAIL : DATA_LO;
                  end
               end
               DATA_LO: begin
                  if (byte_valid) begin
                     lo_byte <= shreg;
                     state   <= DATA_HI;
                  end
               end
               DATA_HI: begin
                  if (byte_valid) begin
                     wr_en      <= 1'b1;
                     wr_data    <= DATA_W'({shreg, lo_byte});
                     words_left <= words_left - 16'd1;
                     state      <= (words_left == 16'd1) ? TAIL : DATA_LO;
                  end
               end
`ifdef LOADER_CKSUM_EN
               CKSUM: begin
                  if (byte_valid) begin
                     if (shreg == cksum) begin
                        state <= DONE;
                     end else begin
                        frame_err <= 1'b1;
                        cpu_hold  <= 1'b0;
                        state     <= IDLE;
                     end
                  end
               end
`endif
               DONE: begin
                  load_done <= 1'b1;
                  cpu_hold  <= 1'b0;
                  state     <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   assign bus.wr_en     = wr_en;
   assign bus.wr_addr   = wr_addr;
   assign bus.wr_data   = wr_data;
   assign bus.cpu_hold  = cpu_hold;
   assign bus.load_done = load_done;
   assign bus.frame_err = frame_err;
endmodule
